// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan_driver
// Description : Captures a 16-bit value once per scan frame and multiplexes it
//               as four hex digits onto a common-anode 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter int GHOST_GUARD    = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] test_value,
    input  logic        Hold,
    input  logic        Blank,
    output logic [6:0]  Seg,
    output logic [3:0]  An,
    output logic [15:0] ValueQ,
    output logic        Changed
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_GUARD   = CNT_W'(GHOST_GUARD);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dig;
    logic             w_tick;
    logic             w_frameEnd;
    logic [3:0]       w_nibble;
    logic             w_lzBlank;
    logic             w_anOn;
    logic [3:0]       w_anHigh;
    logic [6:0]       w_segHigh;
    logic [3:0]       w_anDrive;
    logic [6:0]       w_segDrive;
    logic [3:0]       w_anOff;
    logic [6:0]       w_segOff;

    function automatic logic [6:0] hexDecode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign w_tick     = (r_cnt == c_CNT_MAX);
    assign w_frameEnd = w_tick && (r_dig == 2'd3);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_dig <= 2'd0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + c_CNT_ONE;
            if (w_tick) begin
                r_dig <= r_dig + 2'd1;
            end
        end
    end

    // Capture only at frame boundaries so a frame never shows mixed values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ValueQ  <= 16'h0000;
            Changed <= 1'b0;
        end else begin
            Changed <= 1'b0;
            if (w_frameEnd && !Hold) begin
                ValueQ  <= test_value;
                Changed <= (test_value != ValueQ);
            end
        end
    end

    assign w_nibble = ValueQ[{r_dig, 2'b00} +: 4];

    always_comb begin
        w_lzBlank = 1'b0;
        if (LZ_BLANK) begin
            case (r_dig)
                2'd3:    w_lzBlank = (ValueQ[15:12] == 4'h0);
                2'd2:    w_lzBlank = (ValueQ[15:8] == 8'h00);
                2'd1:    w_lzBlank = (ValueQ[15:4] == 12'h000);
                default: w_lzBlank = 1'b0;
            endcase
        end
    end

    // Anodes stay off during the guard window to hide the previous digit's ghost.
    assign w_anOn    = !w_lzBlank && (r_cnt >= c_GUARD) && !Blank;
    assign w_anHigh  = w_anOn ? (4'b0001 << r_dig) : 4'b0000;
    assign w_segHigh = w_lzBlank ? 7'h00 : hexDecode(w_nibble);

    generate
        if (AN_ACTIVE_LOW) begin : g_anActiveLow
            assign w_anDrive = ~w_anHigh;
            assign w_anOff   = 4'hF;
        end else begin : g_anActiveHigh
            assign w_anDrive = w_anHigh;
            assign w_anOff   = 4'h0;
        end

        if (SEG_ACTIVE_LOW) begin : g_segActiveLow
            assign w_segDrive = ~w_segHigh;
            assign w_segOff   = 7'h7F;
        end else begin : g_segActiveHigh
            assign w_segDrive = w_segHigh;
            assign w_segOff   = 7'h00;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            An  <= w_anOff;
            Seg <= w_segOff;
        end else begin
            An  <= w_anDrive;
            Seg <= w_segDrive;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_scan_driver
// Description : Self-checking bench with a phase-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan_driver;

    localparam int R  = 8;
    localparam int G  = 2;
    localparam int FR = 4 * R;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tv = 16'h12AF;
    logic        hold = 1'b0;
    logic        blank = 1'b0;
    logic [6:0]  Seg;
    logic [3:0]  An;
    logic [15:0] ValueQ;
    logic        Changed;

    sevenseg_scan_driver #(
        .REFRESH_DIV   (R),
        .GHOST_GUARD   (G),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1),
        .LZ_BLANK      (1'b1)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .test_value(tv),
        .Hold      (hold),
        .Blank     (blank),
        .Seg       (Seg),
        .An        (An),
        .ValueQ    (ValueQ),
        .Changed   (Changed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    // Model state: cycles elapsed since reset and the captured value.
    int          p = 0;
    int          mVal = 0;
    logic [3:0]  expAn = 4'hF;
    logic [6:0]  expSeg = 7'h7F;
    logic        expChanged = 1'b0;

    function automatic int hexOf(input int n);
        case (n)
            0: return 'h3F;   1: return 'h06;   2: return 'h5B;   3: return 'h4F;
            4: return 'h66;   5: return 'h6D;   6: return 'h7D;   7: return 'h07;
            8: return 'h7F;   9: return 'h6F;   10: return 'h77;  11: return 'h7C;
            12: return 'h39;  13: return 'h5E;  14: return 'h79;  default: return 'h71;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        int cnt, dig, nib, pw;
        if (rst) begin
            p = 0; mVal = 0;
            expAn = 4'hF; expSeg = 7'h7F; expChanged = 1'b0;
        end else begin
            cnt = p % R;
            dig = (p / R) % 4;
            pw  = 1 << (4 * dig);
            nib = (mVal / pw) % 16;
            expAn = 4'hF; expSeg = 7'h7F;
            if (dig == 0 || mVal >= pw) begin
                expSeg = ~7'(hexOf(nib));
                if (cnt >= G && !blank) expAn = ~(4'(1) << dig);
            end
            expChanged = 1'b0;
            if (cnt == R - 1 && dig == 3 && !hold) begin
                expChanged = (int'(tv) != mVal);
                mVal = int'(tv);
            end
            p++;
        end
    end

    always @(negedge clk) begin
        if (cmpEn) begin
            check("An", {28'd0, An}, {28'd0, expAn});
            check("Seg", {25'd0, Seg}, {25'd0, expSeg});
            check("ValueQ", {16'd0, ValueQ}, 32'(mVal));
            check("Changed", {31'd0, Changed}, {31'd0, expChanged});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Step at least once, then until just after a frame capture edge.
    task automatic waitFrameStart();
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while ((p % FR) != 0 && k < 3 * FR);
        if ((p % FR) != 0) check("frameStartTimeout", 32'(k), 32'(FR));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen3, seen2, other, allOff, sawCh;
        logic [6:0] d1Seg, d0Seg;
        int k;

        rst = 1'b1;
        step(1);
        cmpEn = 1'b1;
        check("rstAn", {28'd0, An}, 32'hF);
        check("rstSeg", {25'd0, Seg}, 32'h7F);
        check("rstValueQ", {16'd0, ValueQ}, 32'h0);
        step(1);
        rst = 1'b0;

        // First capture lands 32 cycles after release.
        step(31);
        check("preCapValueQ", {16'd0, ValueQ}, 32'h0);
        step(1);
        check("capValueQ", {16'd0, ValueQ}, 32'h12AF);
        check("capChanged", {31'd0, Changed}, 32'h1);
        step(1);
        check("capChangedOnce", {31'd0, Changed}, 32'h0);
        check("guardAn", {28'd0, An}, 32'hF);
        check("guardSeg", {25'd0, Seg}, 32'h0E);
        step(2);
        check("dig0An", {28'd0, An}, 32'hE);
        check("dig0Seg", {25'd0, Seg}, 32'h0E);
        step(5);
        check("dig0AnEnd", {28'd0, An}, 32'hE);
        step(1);
        check("dig1GuardAn", {28'd0, An}, 32'hF);
        check("dig1Seg", {25'd0, Seg}, 32'h08);

        // Leading-zero blanking with 00A0
        tv = 16'h00A0;
        waitFrameStart();
        step(1);
        seen3 = 0; seen2 = 0; d1Seg = 7'h7F; d0Seg = 7'h7F;
        for (int i = 0; i < FR; i++) begin
            step(1);
            if (!An[3]) seen3 = 1;
            if (!An[2]) seen2 = 1;
            if (An == 4'hD) d1Seg = Seg;
            if (An == 4'hE) d0Seg = Seg;
        end
        check("lzAn3", {31'd0, seen3}, 32'h0);
        check("lzAn2", {31'd0, seen2}, 32'h0);
        check("lzDig1Seg", {25'd0, d1Seg}, 32'h08);
        check("lzDig0Seg", {25'd0, d0Seg}, 32'h40);

        // Zero value shows a single "0"
        tv = 16'h0000;
        waitFrameStart();
        step(1);
        other = 0; d0Seg = 7'h7F;
        for (int i = 0; i < FR; i++) begin
            step(1);
            if (An != 4'hF && An != 4'hE) other = 1;
            if (An == 4'hE) d0Seg = Seg;
        end
        check("zeroOnlyDig0", {31'd0, other}, 32'h0);
        check("zeroSeg", {25'd0, d0Seg}, 32'h40);

        // Hold freezes the display
        tv = 16'h12AF;
        waitFrameStart();
        check("preHoldValueQ", {16'd0, ValueQ}, 32'h12AF);
        hold = 1'b1;
        tv = 16'hBEEF;
        sawCh = 0;
        for (int i = 0; i < 3 * FR; i++) begin
            step(1);
            if (Changed) sawCh = 1;
        end
        check("holdValueQ", {16'd0, ValueQ}, 32'h12AF);
        check("holdChanged", {31'd0, sawCh}, 32'h0);
        hold = 1'b0;
        waitFrameStart();
        check("releaseValueQ", {16'd0, ValueQ}, 32'hBEEF);
        check("releaseChanged", {31'd0, Changed}, 32'h1);
        waitFrameStart();
        check("sameValueChanged", {31'd0, Changed}, 32'h0);
        check("sameValueQ", {16'd0, ValueQ}, 32'hBEEF);

        // Blank for 20 cycles
        step(5);
        blank = 1'b1;
        allOff = 1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (An != 4'hF) allOff = 0;
        end
        blank = 1'b0;
        check("blankAllOff", {31'd0, allOff}, 32'h1);
        step(3 * R);

        // Reset in the middle of the digit2 slot
        k = 0;
        while ((p % FR) != 2 * R + 3 && k < 2 * FR) begin
            step(1);
            k++;
        end
        rst = 1'b1;
        step(1);
        check("midRstAn", {28'd0, An}, 32'hF);
        check("midRstSeg", {25'd0, Seg}, 32'h7F);
        check("midRstValueQ", {16'd0, ValueQ}, 32'h0);
        check("midRstChanged", {31'd0, Changed}, 32'h0);
        step(1);
        rst = 1'b0;
        step(FR - 1);
        check("postRstNoCap", {16'd0, ValueQ}, 32'h0);
        step(1);
        check("postRstCap", {16'd0, ValueQ}, 32'hBEEF);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: tv = 16'($urandom);
                    1: tv = 16'($urandom) >> (4 * $urandom_range(3));
                    2: tv = 16'h0000;
                    default: tv = 16'($urandom_range(15));
                endcase
            end
            if ($urandom_range(15) == 0) hold = ~hold;
            if ($urandom_range(31) == 0) blank = ~blank;
            rst = ($urandom_range(999) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
